sram_responder: RTL and testbench



---
 rtl/sram_pkg.sv | 22 ++
 rtl/sram_array.sv | 50 +++++
 rtl/sram_responder.sv | 188 ++++++++++++++++++
 tb/tb_sram_responder.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/sram_pkg.sv
// Shared definitions for the SRAM responder: pin widths, byte-lane ranges
// and the access-state encoding.
package sram_pkg;

  localparam int unsigned SRAM_ADDR_W = 18;
  localparam int unsigned SRAM_DATA_W = 16;
  localparam int unsigned LANE_W      = 8;

  // Byte lanes of the 16-bit data bus
  localparam int unsigned HI_MSB = 15;
  localparam int unsigned HI_LSB = 8;
  localparam int unsigned LO_MSB = 7;
  localparam int unsigned LO_LSB = 0;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RD_WAIT   = 2'd1,
    RD_DRIVE  = 2'd2,
    WR_ACTIVE = 2'd3
  } state_t;

endpackage

// File: rtl/sram_array.sv
// Word storage for the SRAM responder: two 8-bit banks with independent
// lane write enables, one synchronous read port and one write port.
// A write to the address being read returns the new lane data (write-first).
//
// Ports:
//   clk       clock
//   rd_addr   read word index, sampled every edge
//   rd_data   registered read data
//   wr_addr   write word index
//   wr_data   write data (both lanes)
//   wr_en_hi  write enable for wr_data[15:8]
//   wr_en_lo  write enable for wr_data[7:0]
module sram_array
  import sram_pkg::*;
#(
  parameter int unsigned DEPTH_W = 10
) (
  input  logic                   clk,
  input  logic [DEPTH_W-1:0]     rd_addr,
  output logic [SRAM_DATA_W-1:0] rd_data,
  input  logic [DEPTH_W-1:0]     wr_addr,
  input  logic [SRAM_DATA_W-1:0] wr_data,
  input  logic                   wr_en_hi,
  input  logic                   wr_en_lo
);

  localparam int unsigned DEPTH = 1 << DEPTH_W;

  logic [LANE_W-1:0] bank_hi [DEPTH];
  logic [LANE_W-1:0] bank_lo [DEPTH];
  logic [LANE_W-1:0] rd_hi;
  logic [LANE_W-1:0] rd_lo;

  // Upper byte bank
  always_ff @(posedge clk) begin
    if (wr_en_hi) bank_hi[wr_addr] <= wr_data[HI_MSB:HI_LSB];
    if (wr_en_hi && (wr_addr == rd_addr)) rd_hi <= wr_data[HI_MSB:HI_LSB];
    else                                  rd_hi <= bank_hi[rd_addr];
  end

  // Lower byte bank
  always_ff @(posedge clk) begin
    if (wr_en_lo) bank_lo[wr_addr] <= wr_data[LO_MSB:LO_LSB];
    if (wr_en_lo && (wr_addr == rd_addr)) rd_lo <= wr_data[LO_MSB:LO_LSB];
    else                                  rd_lo <= bank_lo[rd_addr];
  end

  assign rd_data = {rd_hi, rd_lo};

endmodule

// File: rtl/sram_responder.sv
// Clocked emulation of a 256Kx16 asynchronous SRAM as seen from the
// controller pins. All pins are sampled on clk; read latency is counted in
// cycles, writes land when we_n/ce_n rise, byte lanes via ub_n/lb_n.
// Only 2^DEPTH_W words exist; upper address bits alias.
//
// Optional build macro: SRAM_RESPONDER_CHECK_EN enables the sticky protocol
// checker on err; without it err is tied low.
//
// Ports:
//   clk        clock
//   rst        synchronous active-high reset (array contents kept)
//   addr       word address from controller
//   io         bidirectional data pins
//   ce_n       chip enable, active low
//   oe_n       output enable, active low
//   we_n       write enable, active low
//   ub_n       upper byte lane enable, active low
//   lb_n       lower byte lane enable, active low
//   rd_valid   high while io is driven
//   wr_commit  one-cycle pulse when a write lands
//   err        sticky protocol error
module sram_responder
  import sram_pkg::*;
#(
  parameter int unsigned ADDR_W  = SRAM_ADDR_W,
  parameter int unsigned DEPTH_W = 10,
  parameter int unsigned DATA_W  = SRAM_DATA_W,
  parameter int unsigned RD_LAT  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addr,
  inout  logic [DATA_W-1:0] io,
  input  logic              ce_n,
  input  logic              oe_n,
  input  logic              we_n,
  input  logic              ub_n,
  input  logic              lb_n,
  output logic              rd_valid,
  output logic              wr_commit,
  output logic              err
);

  localparam int unsigned LAT_W = 3;

  state_t             state, state_d;
  logic [LAT_W-1:0]   lat_cnt, lat_d;
  logic [ADDR_W-1:0]  prev_addr;
  logic [DEPTH_W-1:0] wr_addr;
  logic [DATA_W-1:0]  wr_data;
  logic [1:0]         wr_be;
  logic               drv_hi, drv_lo;
  logic [DATA_W-1:0]  rd_data;

  logic rd_go_c, wr_go_c, addr_chg_c, capture_c, commit_c;
  logic wr_en_hi_c, wr_en_lo_c;

  assign rd_go_c    = !ce_n && !oe_n && we_n;
  assign wr_go_c    = !ce_n && !we_n;
  assign addr_chg_c = (addr != prev_addr);

  // Next-state logic; write always wins over read
  always_comb begin
    state_d   = state;
    lat_d     = lat_cnt;
    capture_c = 1'b0;
    commit_c  = 1'b0;
    unique case (state)
      IDLE: begin
        if (wr_go_c) begin
          state_d   = WR_ACTIVE;
          capture_c = 1'b1;
        end else if (rd_go_c) begin
          state_d = RD_WAIT;
          lat_d   = LAT_W'(1);
        end
      end
      RD_WAIT: begin
        if (wr_go_c) begin
          state_d   = WR_ACTIVE;
          capture_c = 1'b1;
        end else if (!rd_go_c) begin
          state_d = IDLE;
        end else if (addr_chg_c) begin
          lat_d = LAT_W'(1);
        end else if (lat_cnt == LAT_W'(RD_LAT)) begin
          state_d = RD_DRIVE;
        end else begin
          lat_d = lat_cnt + LAT_W'(1);
        end
      end
      RD_DRIVE: begin
        if (wr_go_c) begin
          state_d   = WR_ACTIVE;
          capture_c = 1'b1;
        end else if (!rd_go_c) begin
          state_d = IDLE;
        end else if (addr_chg_c) begin
          state_d = RD_WAIT;
          lat_d   = LAT_W'(1);
        end
      end
      WR_ACTIVE: begin
        if (wr_go_c) begin
          capture_c = 1'b1;
        end else begin
          commit_c = 1'b1;
          if (rd_go_c) begin
            state_d = RD_WAIT;
            lat_d   = LAT_W'(1);
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A commit coinciding with reset is discarded
  assign wr_en_hi_c = commit_c && !wr_be[1] && !rst;
  assign wr_en_lo_c = commit_c && !wr_be[0] && !rst;

  // Control registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      lat_cnt   <= '0;
      rd_valid  <= 1'b0;
      drv_hi    <= 1'b0;
      drv_lo    <= 1'b0;
      wr_commit <= 1'b0;
    end else begin
      state     <= state_d;
      lat_cnt   <= lat_d;
      rd_valid  <= (state_d == RD_DRIVE);
      drv_hi    <= (state_d == RD_DRIVE) && !ub_n;
      drv_lo    <= (state_d == RD_DRIVE) && !lb_n;
      wr_commit <= commit_c;
    end
  end

  // Address history and write capture; no reset needed
  always_ff @(posedge clk) begin
    prev_addr <= addr;
    if (capture_c) begin
      wr_addr <= addr[DEPTH_W-1:0];
      wr_data <= io;
      wr_be   <= {ub_n, lb_n};
    end
  end

  sram_array #(.DEPTH_W(DEPTH_W)) u_array (
    .clk      (clk),
    .rd_addr  (addr[DEPTH_W-1:0]),
    .rd_data  (rd_data),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .wr_en_hi (wr_en_hi_c),
    .wr_en_lo (wr_en_lo_c)
  );

  assign io[HI_MSB:HI_LSB] = drv_hi ? rd_data[HI_MSB:HI_LSB] : {LANE_W{1'bz}};
  assign io[LO_MSB:LO_LSB] = drv_lo ? rd_data[LO_MSB:LO_LSB] : {LANE_W{1'bz}};

`ifdef SRAM_RESPONDER_CHECK_EN
  logic viol_c;

  // Protocol violations; the X/Z check exists only in simulation
  always_comb begin
    viol_c = 1'b0;
    if ((state == WR_ACTIVE) && !we_n && addr_chg_c) viol_c = 1'b1;
    if (!we_n && !oe_n && !ce_n) viol_c = 1'b1;
`ifndef SYNTHESIS
    if ((ce_n !== 1'b1) && $isunknown({addr, ce_n, oe_n, we_n, ub_n, lb_n}))
      viol_c = 1'b1;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) err <= 1'b0;
    else     err <= err | viol_c;
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_sram_responder.sv
// Randomized self-checking bench for sram_responder. A word-level memory
// model plus the pin-timing rules (read latency, commit on we_n rise, lane
// masking) give every expected value. io is pulled up, so a released lane
// reads as 8'hFF.
module tb_sram_responder;

  localparam int unsigned ADDR_W  = 18;
  localparam int unsigned DEPTH_W = 10;
  localparam int unsigned DATA_W  = 16;
  localparam int unsigned RD_LAT  = 2;
  localparam int unsigned WORDS   = 1 << DEPTH_W;
  localparam logic [15:0] FLOAT   = 16'hFFFF;
`ifdef SRAM_RESPONDER_CHECK_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic [ADDR_W-1:0] addr;
  tri1  [DATA_W-1:0] io;
  logic              ce_n, oe_n, we_n, ub_n, lb_n;
  logic              rd_valid, wr_commit, err;
  logic              tb_drive;
  logic [DATA_W-1:0] tb_data;

  logic [15:0] model [WORDS];
  int checks   = 0;
  int failures = 0;

  assign io = tb_drive ? tb_data : 16'hzzzz;

  always #5 clk = ~clk;

  sram_responder #(
    .ADDR_W(ADDR_W), .DEPTH_W(DEPTH_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT)
  ) dut (
    .clk(clk), .rst(rst), .addr(addr), .io(io), .ce_n(ce_n), .oe_n(oe_n),
    .we_n(we_n), .ub_n(ub_n), .lb_n(lb_n), .rd_valid(rd_valid),
    .wr_commit(wr_commit), .err(err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_pins();
    ce_n = 1'b1; oe_n = 1'b1; we_n = 1'b1;
    ub_n = 1'b0; lb_n = 1'b0; tb_drive = 1'b0;
  endtask

  function automatic logic [15:0] exp_read(input logic [ADDR_W-1:0] a, input logic ub, input logic lb);
    logic [15:0] w;
    w = model[a[DEPTH_W-1:0]];
    return {ub ? 8'hFF : w[15:8], lb ? 8'hFF : w[7:0]};
  endfunction

  // Write with we_n low for n cycles, then release; commit lands on release
  task automatic write_op(input logic [ADDR_W-1:0] a, input logic [15:0] d,
                          input logic ub, input logic lb, input int n);
    logic [15:0] w;
    addr = a; tb_data = d; tb_drive = 1'b1; ub_n = ub; lb_n = lb;
    oe_n = 1'b1; ce_n = 1'b0; we_n = 1'b0;
    for (int i = 0; i < n; i++) begin
      tick();
      check("wr_hold_commit", wr_commit, 0);
      check("wr_hold_valid", rd_valid, 0);
    end
    we_n = 1'b1;
    tick();
    check("wr_commit_pulse", wr_commit, 1);
    w = model[a[DEPTH_W-1:0]];
    if (!ub) w[15:8] = d[15:8];
    if (!lb) w[7:0]  = d[7:0];
    model[a[DEPTH_W-1:0]] = w;
    idle_pins();
    tick();
    check("wr_commit_drop", wr_commit, 0);
  endtask

  // Start (or restart after an address move) a read; data due RD_LAT edges later
  task automatic read_from(input logic [ADDR_W-1:0] a, input logic ub, input logic lb);
    addr = a; ub_n = ub; lb_n = lb; tb_drive = 1'b0;
    ce_n = 1'b0; oe_n = 1'b0; we_n = 1'b1;
    for (int i = 0; i < int'(RD_LAT); i++) begin
      tick();
      check("rd_lat_valid", rd_valid, 0);
      check("rd_lat_io", io, FLOAT);
    end
    tick();
    check("rd_valid", rd_valid, 1);
    check("rd_data", io, exp_read(a, ub, lb));
  endtask

  task automatic read_end();
    idle_pins();
    tick();
    check("rd_end_valid", rd_valid, 0);
    check("rd_end_io", io, FLOAT);
  endtask

  function automatic logic [ADDR_W-1:0] rand_addr();
    logic [ADDR_W-1:0] hi;
    hi = ADDR_W'($urandom) & 18'h3FC00;
    return hi | ADDR_W'($urandom_range(0, 31));
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [ADDR_W-1:0] a1, a2;
    logic [15:0] d;
    logic [1:0]  be;

    // Reset hold with a read requested
    rst = 1'b1; addr = 18'h5; tb_data = '0; tb_drive = 1'b0;
    ce_n = 1'b0; oe_n = 1'b0; we_n = 1'b1; ub_n = 1'b0; lb_n = 1'b0;
    repeat (3) begin
      tick();
      check("rst_io", io, FLOAT);
      check("rst_valid", rd_valid, 0);
      check("rst_commit", wr_commit, 0);
      check("rst_err", err, 0);
    end
    idle_pins();
    rst = 1'b0;
    tick();

    // Give the low 32 words known contents
    for (int i = 0; i < 32; i++) write_op(ADDR_W'(i), 16'($urandom), 1'b0, 1'b0, 1);

    // Write then read
    write_op(18'h00005, 16'hBEEF, 1'b0, 1'b0, 2);
    read_from(18'h00005, 1'b0, 1'b0);
    check("beef_const", io, 16'hBEEF);
    read_end();

    // Byte lanes
    write_op(18'h00007, 16'h1234, 1'b0, 1'b0, 1);
    write_op(18'h00007, 16'hABCD, 1'b1, 1'b0, 1);
    read_from(18'h00007, 1'b0, 1'b0);
    check("lane_merge_const", io, 16'h12CD);
    read_end();
    read_from(18'h00007, 1'b0, 1'b1);
    read_end();

    // Aliasing of upper address bits
    write_op(18'h00403, 16'h5A5A, 1'b0, 1'b0, 1);
    read_from(18'h00003, 1'b0, 1'b0);
    check("alias_const", io, 16'h5A5A);
    read_end();

    // Address move while driving: release, then new data after the latency
    read_from(18'h00005, 1'b0, 1'b0);
    read_from(18'h00007, 1'b0, 1'b0);
    read_end();

    // Both lanes disabled: pulse but no change
    write_op(18'h00009, 16'h0F0F, 1'b1, 1'b1, 2);
    read_from(18'h00009, 1'b0, 1'b0);
    read_end();

    // Reset during a write discards it
    addr = 18'h0000A; tb_data = 16'hC3C3; tb_drive = 1'b1;
    ub_n = 1'b0; lb_n = 1'b0; oe_n = 1'b1; ce_n = 1'b0; we_n = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    idle_pins();
    tick();
    check("rst_wr_commit", wr_commit, 0);
    rst = 1'b0;
    tick();
    check("rst_wr_commit2", wr_commit, 0);
    read_from(18'h0000A, 1'b0, 1'b0);
    read_end();

    // Randomized traffic
    for (int it = 0; it < 60; it++) begin
      a1 = rand_addr();
      if ($urandom_range(0, 1) == 0) begin
        d  = 16'($urandom);
        be = 2'($urandom);
        write_op(a1, d, be[1], be[0], int'($urandom_range(1, 3)));
      end else begin
        be = 2'($urandom);
        read_from(a1, be[1], be[0]);
        if ($urandom_range(0, 1) == 0) begin
          a2 = rand_addr();
          if (a2 == a1) a2 = a2 ^ 18'h1;
          read_from(a2, 1'b0, 1'b0);
        end
        read_end();
      end
    end

    // Simultaneous we_n/oe_n: write wins, io stays released
    addr = 18'h00011; ub_n = 1'b1; lb_n = 1'b1; tb_drive = 1'b0;
    ce_n = 1'b0; we_n = 1'b0; oe_n = 1'b0;
    tick();
    check("chk_err_set", err, 32'(EXP_ERR));
    check("chk_io", io, FLOAT);
    check("chk_valid", rd_valid, 0);
    idle_pins();
    tick();
    check("chk_commit", wr_commit, 1);
    check("chk_io2", io, FLOAT);
    repeat (3) begin
      tick();
      check("chk_err_sticky", err, 32'(EXP_ERR));
    end
    read_from(18'h00011, 1'b0, 1'b0);
    read_end();
    rst = 1'b1;
    tick();
    check("chk_err_clear", err, 0);
    rst = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
